// File: rtl/multimode_wave_generator.sv
// Multi-mode duty-cycle source (square, rising saw, triangle, falling saw) feeding the PWM block.
// Programmable phase rate, clip scaling, mode switching only at period boundaries.
module multimode_wave_generator #(
    parameter int DUTY_W  = 7,
    parameter int PHASE_W = 6,
    parameter int PRESC_W = 6
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] rate_div,
    input  logic [2:0]         clip_factor,
    output logic [DUTY_W-1:0]  duty_output,
    output logic               cycle_start,
    output logic [1:0]         active_mode
);

    if (PHASE_W > DUTY_W - 1) begin : g_cfg_check
        $error("multimode_wave_generator: PHASE_W must not exceed DUTY_W-1");
    end

    localparam int SH = DUTY_W - 1 - PHASE_W;
    localparam logic [DUTY_W-1:0]  FS      = {1'b1, {(DUTY_W-1){1'b0}}};
    localparam logic [PHASE_W-1:0] PH_MAX  = '1;
    localparam logic [PHASE_W-1:0] PH_HALF = {1'b1, {(PHASE_W-1){1'b0}}};

    logic [PRESC_W-1:0] presc_cnt;
    logic [PHASE_W-1:0] phase;
    logic               started;
    logic               wrap_d;

    logic               tick;
    logic               wrap;
    logic               first_half;
    logic [DUTY_W-1:0]  phase_ext;
    logic [DUTY_W-1:0]  mirror_ext;
    logic [DUTY_W-1:0]  raw;
    logic [2:0]         divisor;
    logic [DUTY_W-1:0]  scaled;

    always_comb begin
        // '>=' so a rate_div lowered below the running count ticks at once
        tick       = (presc_cnt >= rate_div);
        wrap       = tick && (phase == PH_MAX);
        first_half = (phase < PH_HALF);
        phase_ext  = DUTY_W'(phase);
        mirror_ext = DUTY_W'(PH_MAX - phase);
        raw        = '0;
        case (active_mode)
            2'd0:    raw = first_half ? FS : '0;
            2'd1:    raw = phase_ext << SH;
            2'd2:    raw = (first_half ? phase_ext : mirror_ext) << (SH + 1);
            default: raw = mirror_ext << SH;
        endcase
        divisor = (clip_factor <= 3'd1) ? 3'd1 : clip_factor;
        scaled  = raw / DUTY_W'(divisor);
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt   <= '0;
            phase       <= '0;
            started     <= 1'b0;
            wrap_d      <= 1'b0;
            duty_output <= '0;
            cycle_start <= 1'b0;
            active_mode <= 2'd0;
        end else if (!enable) begin
            presc_cnt   <= '0;
            phase       <= '0;
            started     <= 1'b0;
            wrap_d      <= 1'b0;
            duty_output <= '0;
            cycle_start <= 1'b0;
        end else if (!started) begin
            // Start cycle behaves like a wrap: latch mode, flag the first output as a period start
            started     <= 1'b1;
            active_mode <= mode;
            wrap_d      <= 1'b1;
            presc_cnt   <= '0;
            phase       <= '0;
            duty_output <= '0;
            cycle_start <= 1'b0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
            if (tick) begin
                phase <= phase + PHASE_W'(1);
            end
            if (wrap) begin
                active_mode <= mode;
            end
            wrap_d      <= wrap;
            cycle_start <= wrap_d;
            duty_output <= scaled;
        end
    end

endmodule
